// File: rtl/lsu_rmw_pkg.sv
// Shared encodings for the lsu_rmw load/store initiator: access sizes, FSM states,
// lane-select constants and the latched request payload.
package lsu_rmw_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Half lanes are picked by addr[1], byte lanes by addr[1:0].
    localparam logic       LANE_HALF_LO = 1'b0;
    localparam logic       LANE_HALF_HI = 1'b1;
    localparam logic [1:0] LANE_B0      = 2'd0;
    localparam logic [1:0] LANE_B1      = 2'd1;
    localparam logic [1:0] LANE_B2      = 2'd2;
    localparam logic [1:0] LANE_B3      = 2'd3;

    typedef struct packed {
        logic              we;
        size_e             size;
        logic              sgn;
        logic [1:0]        lo;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: extract/extend for loads, lane merge for sub-word stores.
module lsu_lane_unit
    import lsu_rmw_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        lo_i,
    input  logic              sgn_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] ld_data_c_o,
    output logic [DATA_W-1:0] mrg_data_c_o
);

    logic [HALF_W-1:0] half;
    logic [BYTE_W-1:0] byt;

    always_comb begin
        half = (lo_i[1] == LANE_HALF_HI) ? word_i[31:16] : word_i[15:0];
        case (lo_i)
            LANE_B1: byt = word_i[15:8];
            LANE_B2: byt = word_i[23:16];
            LANE_B3: byt = word_i[31:24];
            default: byt = word_i[7:0];
        endcase

        ld_data_c_o  = word_i;
        mrg_data_c_o = wdata_i;
        case (size_i)
            SZ_HALF: begin
                ld_data_c_o  = {{(DATA_W-HALF_W){sgn_i & half[HALF_W-1]}}, half};
                mrg_data_c_o = word_i;
                if (lo_i[1] == LANE_HALF_HI) mrg_data_c_o[31:16] = wdata_i[15:0];
                else                         mrg_data_c_o[15:0]  = wdata_i[15:0];
            end
            SZ_BYTE: begin
                ld_data_c_o  = {{(DATA_W-BYTE_W){sgn_i & byt[BYTE_W-1]}}, byt};
                mrg_data_c_o = word_i;
                mrg_data_c_o[BYTE_W*32'(lo_i) +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store initiator with read-modify-write for sub-word stores on a word RAM.
// LSU_ALIGN_EXC_EN: when defined, misaligned or illegal-size requests raise resp_exc_o.
module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int unsigned       PHYS_LW     = 10,
    parameter logic [DATA_W-1:0] RESET_RDATA = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_signed_i,
    input  logic [31:0]        req_addr_i,
    input  logic [DATA_W-1:0]  req_wdata_i,
    output logic               resp_valid_o,
    output logic [DATA_W-1:0]  resp_rdata_o,
    output logic               resp_exc_o,
    output logic [PHYS_LW-1:0] mem_addr_o,
    output logic               mem_we_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_exc_q, resp_exc_d;
    logic [PHYS_LW-1:0]  mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    size_e               size_n;
    logic [1:0]          lo_n;
    logic                exc_c;
    logic [DATA_W-1:0]   ld_data_c, mrg_data_c;
    logic                unused_addr_c;

    assign unused_addr_c = ^req_addr_i[31:PHYS_LW+2];

    // Request qualification: either trap misalignment or silently align the address.
`ifdef LSU_ALIGN_EXC_EN
    always_comb begin
        size_n = size_e'(req_size_i);
        lo_n   = req_addr_i[1:0];
        exc_c  = (req_size_i == SZ_ILL)
              || (req_size_i == SZ_HALF && req_addr_i[0])
              || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
    end
`else
    always_comb begin
        size_n = (req_size_i == SZ_ILL) ? SZ_WORD : size_e'(req_size_i);
        exc_c  = 1'b0;
        case (size_n)
            SZ_HALF: lo_n = {req_addr_i[1], 1'b0};
            SZ_BYTE: lo_n = req_addr_i[1:0];
            default: lo_n = 2'b00;
        endcase
    end
`endif

    lsu_lane_unit u_lane (
        .size_i       (req_q.size),
        .lo_i         (req_q.lo),
        .sgn_i        (req_q.sgn),
        .word_i       (mem_rdata_i),
        .wdata_i      (req_q.wdata),
        .ld_data_c_o  (ld_data_c),
        .mrg_data_c_o (mrg_data_c)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_exc_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d.we    = req_we_i;
                    req_d.size  = size_n;
                    req_d.sgn   = req_signed_i;
                    req_d.lo    = lo_n;
                    req_d.wdata = req_wdata_i;
                    ready_d     = 1'b0;
                    if (exc_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_exc_d   = 1'b1;
                    end else begin
                        mem_addr_d = req_addr_i[PHYS_LW+1:2];
                        // Full-word stores skip the read: nothing to preserve.
                        if (req_we_i && size_n == SZ_WORD) begin
                            state_d     = ST_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata_i;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                if (req_q.we) begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = mrg_data_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = ld_data_c;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_exc_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rdata_q      <= RESET_RDATA;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_exc_q   <= resp_exc_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_exc_o   = resp_exc_q;
    assign resp_rdata_o = rdata_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: directed cases plus random traffic against a byte-array memory model.
// Exception cases are exercised only when LSU_ALIGN_EXC_EN is defined.
module tb_lsu_rmw;

    localparam int unsigned PHYS_LW = 10;
    localparam int unsigned DEPTH   = 1 << PHYS_LW;
    localparam int unsigned BYTES   = 4 * DEPTH;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid, req_ready, req_we, req_signed;
    logic [1:0]         req_size;
    logic [31:0]        req_addr, req_wdata;
    logic               resp_valid, resp_exc;
    logic [31:0]        resp_rdata;
    logic [PHYS_LW-1:0] mem_addr;
    logic               mem_we;
    logic [31:0]        mem_wdata, mem_rdata;

    logic [31:0]        ram [DEPTH];
    logic               pk_en = 1'b0;
    logic [PHYS_LW-1:0] pk_addr = '0;
    logic [31:0]        pk_data = '0;

    logic [7:0]         ref_b [BYTES];
    logic [31:0]        exp_rdata;
    int                 n_vec  = 0;
    int                 n_fail = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.PHYS_LW(PHYS_LW), .RESET_RDATA(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_exc_o   (resp_exc),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous-read RAM with a side port for preloading.
    always @(posedge clk) begin
        if (pk_en)       ram[pk_addr]  <= pk_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic poke(input int w, input logic [31:0] d);
        pk_en   = 1'b1;
        pk_addr = PHYS_LW'(w);
        pk_data = d;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // One request through the handshake, checked against the byte-level model.
    task automatic xact(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int     n, ea, lat, got, we_cnt, waitc;
        bit     exc;
        longint v;
        exc = 1'b0;
`ifdef LSU_ALIGN_EXC_EN
        exc = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b00 && addr[1:0] != 2'b00);
`endif
        n   = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
        ea  = int'(addr % 32'(BYTES)) & ~(n - 1);
        lat = exc ? 1 : !we ? 3 : (n == 4) ? 2 : 4;

        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        chk("ready_low_after_accept", 32'(req_ready), 32'd0);

        got = 0; we_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1 && !exc) chk("mem_addr", 32'(mem_addr), 32'(ea / 4));
            if (mem_we === 1'b1) we_cnt++;
            if (resp_valid === 1'b1) begin
                got = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("resp_latency", 32'(got), 32'(lat));
        chk("resp_exc", 32'(resp_exc), 32'(exc));
        chk("we_cycles", 32'(we_cnt), (we && !exc) ? 32'd1 : 32'd0);

        if (!exc && !we) begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(ref_b[ea+i]) << (8 * i);
            if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
            exp_rdata = 32'(v);
        end
        if (!exc && we)
            for (int i = 0; i < n; i++) ref_b[ea+i] = wd[8*i +: 8];
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("ram_word", ram[ea/4], ref_word(ea / 4));

        @(posedge clk); #1;
        chk("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rsz;
        logic [31:0] raddr;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        exp_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_exc", 32'(resp_exc), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        for (int w = 0; w < 32; w++) poke(w, $urandom);

        // Signed and unsigned byte loads from lane 1 of word 3.
        poke(3, 32'h8899_AABB);
        xact(1'b0, 2'b10, 1'b1, 32'h0000_000D, 32'h0, 1'b0);
        chk("ld_byte_signed", resp_rdata, 32'hFFFF_FFAA);
        xact(1'b0, 2'b10, 1'b0, 32'h0000_000D, 32'h0, 1'b0);
        chk("ld_byte_unsigned", resp_rdata, 32'h0000_00AA);

        // Byte store merge into lane 2.
        poke(3, 32'h1122_3344);
        xact(1'b1, 2'b10, 1'b0, 32'h0000_000E, 32'h0000_005A, 1'b0);
        chk("st_byte_merge", ram[3], 32'h115A_3344);

        xact(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        chk("st_word", ram[4], 32'hDEAD_BEEF);

`ifdef LSU_ALIGN_EXC_EN
        xact(1'b0, 2'b01, 1'b1, 32'h0000_0021, 32'h0, 1'b0);
        xact(1'b1, 2'b00, 1'b0, 32'h0000_0032, 32'h1234_5678, 1'b0);
        xact(1'b1, 2'b11, 1'b0, 32'h0000_0030, 32'h1234_5678, 1'b0);
`endif

        // Reset asserted while the half store sits in its write cycle.
        poke(8, 32'hCAFE_F00D);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h0000_0022; req_wdata = 32'h0000_1357;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_we_in_wr", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async_drop", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_rdata = 32'h0;
        @(posedge clk); #1;
        chk("abort_ram_kept", ram[8], 32'hCAFE_F00D);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);

        // Back-to-back loads with req_valid held high throughout.
        poke(0, 32'h0102_0304);
        poke(1, 32'hA5A5_5A5A);
        xact(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 1'b1);
        chk("b2b_first", resp_rdata, 32'h0102_0304);
        xact(1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        chk("b2b_second", resp_rdata, 32'hA5A5_5A5A);

        // Random mix; upper address bits exercise wrap-around.
        for (int i = 0; i < 80; i++) begin
            rsz   = 2'($urandom_range(0, 3));
            raddr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
            xact(1'($urandom), rsz, 1'($urandom), raddr, $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
